// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: per-digit slot timing, 16-phase PWM brightness, hex decode.
// Optional leading-zero blanking is built only when SEG_SCAN_DRIVER_LZB_EN is defined.
module seg_scan_driver #(
  parameter int FCLK  = 50000000,
  parameter int FSLOT = 1000,
  parameter int NDIG  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] dat,
  input  logic [NDIG-1:0]   dp,
  input  logic              load,
  input  logic [3:0]        bright,
  input  logic              lzb,
  output logic [NDIG-1:0]   AN,
  output logic [6:0]        seg,
  output logic              seg_P,
  output logic              ce_slot,
  output logic              frame
);

  localparam int SLOT_CLKS = FCLK / FSLOT;
  localparam int PH_CLKS   = SLOT_CLKS / 16;
  localparam int SW        = (PH_CLKS > 1) ? $clog2(PH_CLKS) : 1;
  localparam int IW        = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(PH_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  // The prescaler is held as {phase_r, sub_r}, so the phase needs no divider.
  logic [SW-1:0]     sub_r;
  logic [3:0]        phase_r;
  logic [IW-1:0]     idx_r;
  logic [3:0]        bright_q;
  logic [4*NDIG-1:0] shadow_dat_r;
  logic [NDIG-1:0]   shadow_dp_r;
  logic [3:0]        nib_s;
  logic              blank_s;
  logic [NDIG-1:0]   an_next_s;
  logic [6:0]        seg_next_s;
  logic              seg_p_next_s;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      4'hF: g = 7'b0001110;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  assign ce_slot = (phase_r == 4'd15) && (sub_r == SUB_LAST);
  assign frame   = ce_slot && (idx_r == IDX_LAST);

`ifdef SEG_SCAN_DRIVER_LZB_EN
  logic [NDIG-1:0] lead_zero_s;

  // Mark digits that sit above the most significant nonzero nibble; digit 0 is never marked.
  always_comb begin
    logic run;
    run         = 1'b1;
    lead_zero_s = '0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      run            = run & (shadow_dat_r[4*i +: 4] == 4'd0);
      lead_zero_s[i] = run;
    end
  end

  assign blank_s = lzb & lead_zero_s[idx_r];
`else
  logic unused_lzb;
  assign unused_lzb = lzb;
  assign blank_s    = 1'b0;
`endif

  // Next-output computation from the current index, phase and shadow contents.
  always_comb begin
    nib_s        = shadow_dat_r[4*idx_r +: 4];
    an_next_s    = '1;
    seg_next_s   = 7'b1111111;
    seg_p_next_s = 1'b1;
    if (phase_r < bright_q) begin
      an_next_s    = ~(NDIG'(1) << idx_r);
      seg_next_s   = blank_s ? 7'b1111111 : hex7(nib_s);
      seg_p_next_s = ~shadow_dp_r[idx_r];
    end else begin
      an_next_s    = '1;
      seg_next_s   = 7'b1111111;
      seg_p_next_s = 1'b1;
    end
  end

  // Slot timing, digit index, brightness sampling, shadow load and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_r        <= '0;
      phase_r      <= 4'd0;
      idx_r        <= '0;
      bright_q     <= 4'd0;
      shadow_dat_r <= '0;
      shadow_dp_r  <= '0;
      AN           <= '1;
      seg          <= 7'b1111111;
      seg_P        <= 1'b1;
    end else begin
      if (sub_r == SUB_LAST) begin
        sub_r   <= '0;
        phase_r <= phase_r + 4'd1;
      end else begin
        sub_r   <= sub_r + SW'(1);
      end
      if (ce_slot) begin
        bright_q <= bright;
        idx_r    <= (idx_r == IDX_LAST) ? '0 : idx_r + IW'(1);
      end
      if (load) begin
        shadow_dat_r <= dat;
        shadow_dp_r  <= dp;
      end
      AN    <= an_next_s;
      seg   <= seg_next_s;
      seg_P <= seg_p_next_s;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
Parameters:
REQ-001 FCLK, 50000000, clock frequency in Hz.
REQ-002 FSLOT, 1000, digit-slot rate in Hz; SLOT_CLKS = FCLK/FSLOT SHALL be a multiple of 16 and at least 16.
REQ-003 NDIG, 4, number of digits, legal range 1..8.
Ports:
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 dat  in  4*NDIG  hex nibbles; nibble i drives digit i, digit 0 least significant.
REQ-007 dp  in  NDIG  decimal point request per digit, 1 = lit.
REQ-008 load  in  1  one-cycle strobe capturing dat and dp into shadow registers.
REQ-009 bright  in  4  brightness 0..15 (0 = dark).
REQ-010 lzb  in  1  leading-zero blanking request (effective only with macro, REQ-031).
REQ-011 AN  out  NDIG  anodes, active-low, one-hot-low or all-high.
REQ-012 seg  out  7  segments gfedcba, active-low.
REQ-013 seg_P  out  1  decimal point, active-low.
REQ-014 ce_slot  out  1  one-cycle pulse at the last clock of every digit slot.
REQ-015 frame  out  1  one-cycle pulse coincident with ce_slot when the last digit (NDIG-1) slot ends.

Function
REQ-016 Prescaler SHALL count 0..SLOT_CLKS-1 and wrap; ce_slot = 1 when prescaler == SLOT_CLKS-1.
REQ-017 Digit index SHALL advance 0,1,..,NDIG-1,0 on each ce_slot; NDIG=1 keeps index 0.
REQ-018 Each slot SHALL be split into 16 phases of SLOT_CLKS/16 clocks; phase = prescaler / (SLOT_CLKS/16).
REQ-019 Brightness SHALL be sampled into bright_q on ce_slot only; mid-slot changes take effect at the next slot.
REQ-020 Selected anode SHALL be low only while phase < bright_q; phase 15 is therefore always dark (anti-ghost gap); bright_q = 0 keeps AN all-high.
REQ-021 On load, shadow SHALL take dat/dp on the next edge; display logic SHALL read only the shadow; load coincident with ce_slot SHALL be honoured with no lost update.
REQ-022 Segment decode SHALL map nibble 0..F to standard hex glyphs (0,1,2,3,4,5,6,7,8,9,A,b,C,d,E,F); e.g. 0 -> 1000000, 8 -> 0000000, F -> 0001110.
REQ-023 seg_P SHALL be !shadow_dp[index] while the anode is active, else 1.
REQ-024 AN, seg, seg_P SHALL be registered: they reflect index/phase/shadow of the previous clock (latency 1 clock).
REQ-025 While AN is all-high, seg SHALL be 1111111 and seg_P 1.
REQ-026 ce_slot and frame SHALL be combinational from the prescaler/index, not registered.

Reset
REQ-027 rst SHALL, on the next edge, set prescaler 0, index 0, bright_q 0, shadow dat/dp 0, AN all-high, seg 1111111, seg_P 1.
REQ-028 rst asserted mid-slot or coincident with load SHALL win; load is discarded.
REQ-029 First digit slot after rst release SHALL be dark (bright_q = 0) until the first ce_slot samples bright.

Configuration
REQ-030 Macro SEG_SCAN_DRIVER_LZB_EN controls leading-zero blanking.
REQ-031 Defined: with lzb = 1, digits from NDIG-1 downward whose shadow nibble is 0 SHALL show seg 1111111 up to the first nonzero digit; digit 0 is never blanked; AN and seg_P behave normally for blanked digits.
REQ-032 Undefined: lzb SHALL be ignored and every digit decoded; the blanking logic SHALL not be present.

Verification
(Bench parameters: FCLK=1600, FSLOT=100, NDIG=4 -> SLOT_CLKS=16, phase = prescaler.)
REQ-033 rst 3 cycles, release, bright=15 -> AN=1111 through first slot; ce_slot at clock 15; frame every 64 clocks on index 3 slot end.
REQ-034 load dat=16'h12AF, dp=4'b0100, bright=15 -> digit 0 shows F (0001110), digit 2 shows 2 (0100100) with seg_P=0, others seg_P=1; each anode low 15 of 16 clocks.
REQ-035 bright=4 then bright=0 mid-slot -> active anode low exactly 4 clocks per slot; dark from the following slot onward.
REQ-036 With SEG_SCAN_DRIVER_LZB_EN, lzb=1, dat=16'h0005 -> digits 3..1 seg 1111111, digit 0 shows 5 (0010010); dat=16'h0000 -> digit 0 shows 0; without macro, digits 3..1 show 0 (1000000).
REQ-037 load coincident with ce_slot, then rst asserted during phase 7 -> new data visible next slot; after rst, outputs at reset values on the next edge, shadow = 0.
